// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the ALU.
// It runs a req/gnt/rvalid handshake to data memory, builds byte enables and
// lane-replicated store data, and sign- or zero-extends load data.
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
// Without it, the low address bits are forced to natural alignment.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [3:0]        be_q;
  logic [29:0]       waddr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              bus_err_q;
  logic              mis_q;

  logic              legal_c;
  logic              misal_c;
  logic              accept_c;
  logic              timeout_c;
  logic [1:0]        off_c;
  logic [3:0]        be_c;
  logic [31:0]       wrep_c;
  logic [31:0]       lane_c;
  logic [31:0]       ld_c;

  // Decode the incoming op: legality, alignment, byte enables, store lanes
  always_comb begin
    legal_c = 1'b0;
    misal_c = 1'b0;
    off_c   = addr[1:0];
    be_c    = 4'b1111;
    wrep_c  = wdata;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal_c = 1'b1;
      3'b100, 3'b101:         legal_c = ~op_we;
      default:                legal_c = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        be_c   = 4'b0001 << off_c;
        wrep_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        misal_c = addr[0];
        off_c   = {addr[1], 1'b0};
        be_c    = 4'b0011 << off_c;
        wrep_c  = {2{wdata[15:0]}};
      end
      default: begin
        misal_c = |addr[1:0];
        off_c   = 2'b00;
      end
    endcase
`ifndef MISALIGN_TRAP_EN
    misal_c = 1'b0;
`endif
  end

  assign accept_c  = (state_q == IDLE) && op_valid && legal_c && !misal_c;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Pick the addressed lane of the returned word and extend it
  always_comb begin
    lane_c = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b001:  ld_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b100:  ld_c = {24'h000000, lane_c[7:0]};
      3'b101:  ld_c = {16'h0000, lane_c[15:0]};
      default: ld_c = mem_rdata;
    endcase
  end

  // Next-state logic and the combinational stall
  always_comb begin
    state_d   = state_q;
    lsu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          lsu_stall = 1'b1;
          state_d   = (legal_c && !misal_c) ? REQ : DONE;
        end
      end
      REQ: begin
        lsu_stall = 1'b1;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        lsu_stall = 1'b1;
        if (mem_rvalid || timeout_c) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, access capture, timeout counter and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      be_q      <= 4'b0000;
      waddr_q   <= 30'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= '0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= ((state_q == IDLE) && op_valid && !legal_c) ||
                   ((state_q == WAIT) && !mem_rvalid && timeout_c);
      mis_q     <= (state_q == IDLE) && op_valid && legal_c && misal_c;
      if (accept_c) begin
        we_q    <= op_we;
        f3_q    <= funct3;
        off_q   <= off_c;
        be_q    <= be_c;
        waddr_q <= addr[31:2];
        wdata_q <= wrep_c;
      end
      if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
      else                 cnt_q <= '0;
      if ((state_q == WAIT) && mem_rvalid && !we_q) rdata_q <= ld_c;
    end
  end

  assign done         = (state_q == DONE);
  assign bus_err      = bus_err_q;
  assign misalign_err = mis_q;
  assign rdata_out    = rdata_q;
  assign mem_req      = (state_q == REQ);
  assign mem_we       = (state_q == REQ) && we_q;
  assign mem_be       = (state_q == REQ) ? be_q : 4'b0000;
  assign mem_addr     = {waddr_q, 2'b00};
  assign mem_wdata    = wdata_q;

endmodule
